mem_seq: RTL and testbench

MEM_SEQ -- requirements
Module: mem_seq

---
 rtl/mem_seq.sv | 150 +++++++++++++++
 tb/tb_mem_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mem_seq
//  Purpose  : Two-port (fetch / data) round-robin sequencer for an
//             asynchronous SRAM with active-low strobes. Each transaction runs
//             SETUP -> ACCESS (WAIT_STATES+1 cycles) -> DONE, then back to IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_seq #(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] rdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_drive,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_fetch_q;   // 1: fetch port was granted last, 0: data port
  logic        gnt_fetch_q;    // port owning the transaction in flight
  logic        we_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        drive_q;
  logic        f_ack_q;
  logic        d_ack_q;
  logic [15:0] rdata_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        w_pick_fetch;

  // Round-robin pick: a lone requester always wins, a tie goes to the port not granted last
  always_comb begin
    w_pick_fetch = f_req & (~d_req | ~last_fetch_q);
  end

  // Transaction FSM; every SRAM strobe and ack is registered alongside the state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_fetch_q <= 1'b0;
      gnt_fetch_q  <= 1'b0;
      we_q         <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      drive_q      <= 1'b0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      rdata_q      <= 16'd0;
      addr_q       <= 16'd0;
      wdata_q      <= 16'd0;
    end else begin
      // Acks are single-cycle pulses raised only on the ACCESS -> DONE edge
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (f_req | d_req) begin
            state_q      <= S_SETUP;
            gnt_fetch_q  <= w_pick_fetch;
            last_fetch_q <= w_pick_fetch;
            ce_n_q       <= 1'b0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            if (w_pick_fetch) begin
              // Fetches are always reads; the write-data register is left alone
              addr_q  <= f_addr;
              we_q    <= 1'b0;
              drive_q <= 1'b0;
            end else begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              we_q    <= d_we;
              drive_q <= d_we;
            end
          end
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
          cnt_q   <= C_WAIT;
          oe_n_q  <= we_q;
          we_n_q  <= ~we_q;
        end
        S_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            f_ack_q <= gnt_fetch_q;
            d_ack_q <= ~gnt_fetch_q;
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_drive = drive_q;
  assign Mem_CE    = ce_n_q;
  assign Mem_OE    = oe_n_q;
  assign Mem_WE    = we_n_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_seq
//  Purpose  : Self-checking bench for mem_seq. Two instances (WAIT_STATES=2
//             and WAIT_STATES=0) share one stimulus stream; each is compared
//             every cycle against a transaction-phase reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = 16'd0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'd0;
  logic [15:0] d_wdata = 16'd0;
  logic [15:0] mem_rdata = 16'd0;

  logic        f_ack_a, d_ack_a, drive_a, ce_a, oe_a, we_a, busy_a;
  logic [15:0] rdata_a, maddr_a, mwdata_a;
  logic        f_ack_b, d_ack_b, drive_b, ce_b, oe_b, we_b, busy_b;
  logic [15:0] rdata_b, maddr_b, mwdata_b;

  always #5 Clk = ~Clk;

  mem_seq #(.WAIT_STATES(2)) u_dut_ws2 (
    .Clk(Clk), .Reset(Reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack_a),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack_a),
    .rdata(rdata_a), .mem_rdata(mem_rdata), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
    .mem_drive(drive_a), .Mem_CE(ce_a), .Mem_OE(oe_a), .Mem_WE(we_a), .busy(busy_a)
  );

  mem_seq #(.WAIT_STATES(0)) u_dut_ws0 (
    .Clk(Clk), .Reset(Reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack_b),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack_b),
    .rdata(rdata_b), .mem_rdata(mem_rdata), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
    .mem_drive(drive_b), .Mem_CE(ce_b), .Mem_OE(oe_b), .Mem_WE(we_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ph = -1 when idle, otherwise cycles elapsed since grant
  // (0 = setup, 1..ws+1 = access, ws+2 = done).
  int          ph [2];
  int          wsv [2];
  logic        m_we [2];
  logic        m_fetch [2];
  logic        m_last_fetch [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rdata [2];

  int acks_a[$];   // 1 = fetch ack, 2 = data ack (WAIT_STATES=2 instance)
  int acks_b[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset_all();
    for (int k = 0; k < 2; k++) begin
      ph[k] = -1; m_we[k] = 1'b0; m_fetch[k] = 1'b0; m_last_fetch[k] = 1'b0;
      m_addr[k] = 16'd0; m_wdata[k] = 16'd0; m_rdata[k] = 16'd0;
    end
  endtask

  // Advance the model by one rising edge using the inputs presented at that edge
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        ph[k] = -1; m_we[k] = 1'b0; m_fetch[k] = 1'b0; m_last_fetch[k] = 1'b0;
        m_addr[k] = 16'd0; m_wdata[k] = 16'd0; m_rdata[k] = 16'd0;
      end else if (ph[k] < 0) begin
        if (f_req || d_req) begin
          m_fetch[k] = f_req && (!d_req || !m_last_fetch[k]);
          m_last_fetch[k] = m_fetch[k];
          if (m_fetch[k]) begin
            m_addr[k] = f_addr; m_we[k] = 1'b0;
          end else begin
            m_addr[k] = d_addr; m_we[k] = d_we; m_wdata[k] = d_wdata;
          end
          ph[k] = 0;
        end
      end else begin
        if (ph[k] == wsv[k] + 1 && !m_we[k]) m_rdata[k] = mem_rdata;
        ph[k]++;
        if (ph[k] > wsv[k] + 2) ph[k] = -1;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic fa, input logic da, input logic bz,
                            input logic ce, input logic oe, input logic we, input logic drv,
                            input logic [15:0] rd, input logic [15:0] ma, input logic [15:0] mw);
    string t;
    logic  act, acc, done;
    t    = (k == 0) ? "ws2" : "ws0";
    act  = (ph[k] >= 0) && (ph[k] <= wsv[k] + 1);
    acc  = (ph[k] >= 1) && (ph[k] <= wsv[k] + 1);
    done = (ph[k] == wsv[k] + 2);
    check_val({t, "_busy"},  32'(bz),  32'(ph[k] >= 0));
    check_val({t, "_ce"},    32'(ce),  32'(!act));
    check_val({t, "_oe"},    32'(oe),  32'(!(acc && !m_we[k])));
    check_val({t, "_we"},    32'(we),  32'(!(acc && m_we[k])));
    check_val({t, "_drive"}, 32'(drv), 32'(act && m_we[k]));
    check_val({t, "_fack"},  32'(fa),  32'(done && m_fetch[k]));
    check_val({t, "_dack"},  32'(da),  32'(done && !m_fetch[k]));
    check_val({t, "_rdata"}, 32'(rd),  32'(m_rdata[k]));
    check_val({t, "_maddr"}, 32'(ma),  32'(m_addr[k]));
    check_val({t, "_mwdata"}, 32'(mw), 32'(m_wdata[k]));
    if (k == 0) begin
      if (fa) acks_a.push_back(1);
      if (da) acks_a.push_back(2);
    end else begin
      if (fa) acks_b.push_back(1);
      if (da) acks_b.push_back(2);
    end
  endtask

  // One clock: present inputs, take the edge, then check both instances on the falling edge
  task automatic step(input logic rst, input logic fr, input logic [15:0] fa,
                      input logic dr, input logic dw, input logic [15:0] da,
                      input logic [15:0] dwd, input logic [15:0] mrd);
    Reset = rst; f_req = fr; f_addr = fa; d_req = dr; d_we = dw;
    d_addr = da; d_wdata = dwd; mem_rdata = mrd;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_inst(0, f_ack_a, d_ack_a, busy_a, ce_a, oe_a, we_a, drive_a, rdata_a, maddr_a, mwdata_a);
    check_inst(1, f_ack_b, d_ack_b, busy_b, ce_b, oe_b, we_b, drive_b, rdata_b, maddr_b, mwdata_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234);
  endtask

  initial begin
    wsv[0] = 2; wsv[1] = 0;
    model_reset_all();

    // Reset state
    step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h1234);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_rdata", 32'(rdata_a), 32'd0);

    // Fetch read of 0x3000 returning 0x1234
    step(1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234);
    idle(6);
    check_val("fetch_rdata", 32'(rdata_a), 32'h1234);

    // Data write 0xBEEF to 0x0042; rdata must keep the earlier read value
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0042, 16'hBEEF, 16'h5555);
    idle(6);
    check_val("write_rdata_kept", 32'(rdata_a), 32'h1234);
    check_val("write_mwdata", 32'(mwdata_a), 32'hBEEF);

    // Both ports held after reset: grants must alternate starting with fetch
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    acks_a.delete();
    for (int i = 0; i < 40 && acks_a.size() < 4; i++)
      step(1'b0, 1'b1, 16'(16'h1000 + i), 1'b1, 1'(i & 1), 16'(16'h2000 + i), 16'(i), 16'(16'hA000 + i));
    check_val("rr_ack_count", 32'(acks_a.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < acks_a.size(); i++)
      check_val($sformatf("rr_order%0d", i), 32'(acks_a[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // Reset in the second ACCESS cycle of a write (WAIT_STATES=2 instance)
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    acks_a.delete();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0077, 16'hCAFE, 16'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    check_val("rst_mid_we", 32'(we_a), 32'd1);
    check_val("rst_mid_busy", 32'(busy_a), 32'd0);
    step(1'b0, 1'b1, 16'h0123, 1'b1, 1'b0, 16'h0456, 16'h0, 16'h7777);
    idle(6);
    check_val("rst_mid_acks", 32'(acks_a.size()), 32'd1);
    if (acks_a.size() > 0) check_val("rst_mid_tie_fetch", 32'(acks_a[0]), 32'd1);

    // WAIT_STATES=0: fetch request dropped during SETUP still completes
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    acks_b.delete();
    step(1'b0, 1'b1, 16'h0900, 1'b0, 1'b0, 16'h0, 16'h0, 16'h4321);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h4321);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h4321);
    check_val("ws0_fack_latency", 32'(f_ack_b), 32'd1);
    idle(3);
    check_val("ws0_ack_count", 32'(acks_b.size()), 32'd1);
    check_val("ws0_rdata", 32'(rdata_b), 32'h4321);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) != 0), 16'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
